// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter/sequencer for a shared 4:1 W-bit selector.
// Grants one of four requesters at a time for at most MAX_BURST transfers and
// forwards the granted data downstream with a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req[3:0]   requests (bit 0 = a, 1 = b, 2 = c, 3 = d)
//   a,b,c,d    requester data, W bits each
//   out_ready  downstream accepts y this cycle
//   gnt[3:0]   registered one-hot grant, zero when idle
//   sel[1:0]   registered select, index of the granted requester
//   y          selected data, zero when not granted
//   out_valid  y is valid this cycle
module mux4_rr_arbiter #(
  parameter int unsigned W         = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic         out_ready,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [W-1:0] y,
  output logic         out_valid
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0] y_mux;
  logic         granted;
  logic         xfer;
  logic [1:0]   win;
  logic [1:0]   idx;
  logic         found;

  // Shared selector; a case on sel keeps unselected (possibly X/Z) inputs out of y.
  always_comb begin
    y_mux = '0;
    case (sel_q)
      2'd0: y_mux = a;
      2'd1: y_mux = b;
      2'd2: y_mux = c;
      2'd3: y_mux = d;
      default: y_mux = '0;
    endcase
  end

  assign granted   = (state_q == GRANT);
  assign out_valid = granted & req[sel_q];
  assign y         = granted ? y_mux : '0;
  assign xfer      = out_valid & out_ready;

  // First requester in search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // Release on withdrawal or on the last transfer of the burst.
        if (!req[sel_q] || (xfer && (cnt_q == CNT_LAST))) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

endmodule
